// File: rtl/vram_pkg.sv
// Shared VRAM-copy definitions used by the sync writer and the stream reader.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } sr_state_t;

    localparam int unsigned SKID_DEPTH = 2;

    // Next word address; the top legal address rolls over to 0.
    function automatic int unsigned addr_inc_wrap(input int unsigned addr,
                                                  input int unsigned max_addr);
        return (addr == max_addr) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/vram_stream_reader_if.sv
// Control, RAM read port and output stream of the VRAM stream reader, bundled.
interface vram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] len_m1;
    logic                  busy;
    logic                  done;
    logic                  clr_done;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    // The reader drives the RAM port and the stream.
    modport master (
        input  start, start_addr, len_m1, clr_done, rd_data, out_ready,
        output busy, done, rd_addr, rd_en, out_data, out_valid, out_last
    );

    modport slave (
        output start, start_addr, len_m1, clr_done, rd_data, out_ready,
        input  busy, done, rd_addr, rd_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO with a registered head; entry 0 is always the head word.
module stream_skid_fifo
    import vram_pkg::*;
#(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == 2'(SKID_DEPTH));
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign dout  = ent0_q;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        unique case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = din;
                else                 ent1_d = din;
            end
            2'b01: ent0_d = ent1_q;
            2'b11: begin
                // With one entry the incoming word becomes the new head directly.
                if (count_q == 2'd1) begin
                    ent0_d = din;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = din;
                end
            end
            default: ;
        endcase
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vram_stream_reader.sv
// Streams a contiguous, wrapping VRAM range from a 1-cycle-latency RAM over valid/ready.
// Reads are throttled so buffered plus in-flight words never exceed the skid FIFO depth.
module vram_stream_reader
    import vram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_ADDR   = 2047
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vram_stream_reader_if.master bus
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    sr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      issue_rem_q, issue_rem_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    logic                  issue;
    logic                  start_acc;
    logic                  finish;
    logic                  pop;
    logic [2:0]            occ;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] head_data;

    assign {head_last, head_data} = fifo_dout;
    assign pop = !fifo_empty && bus.out_ready;
    assign occ = {1'b0, fifo_count} + {2'b00, inflight_q};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        issue_rem_d     = issue_rem_q;
        done_d          = done_q;
        issue           = 1'b0;
        start_acc       = 1'b0;
        finish          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc   = 1'b1;
                    addr_d      = (32'(bus.start_addr) > MAX_ADDR) ? '0 : bus.start_addr;
                    issue_rem_d = {1'b0, bus.len_m1} + CNT_W'(1);
                    state_d     = READ;
                end
            end
            READ: begin
                // A word popped this cycle frees its slot in time for the new read.
                if ((occ - {2'b00, pop}) < 3'd2) begin
                    issue       = 1'b1;
                    addr_d      = ADDR_WIDTH'(addr_inc_wrap(32'(addr_q), MAX_ADDR));
                    issue_rem_d = issue_rem_q - CNT_W'(1);
                    if (issue_rem_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.clr_done || start_acc) done_d = 1'b0;
        if (finish)                    done_d = 1'b1;

        inflight_d      = issue;
        inflight_last_d = issue && (issue_rem_q == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            issue_rem_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            issue_rem_q     <= issue_rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // RAM data lands in the FIFO on the edge after its read was issued.
    stream_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   ({inflight_last_q, bus.rd_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    no_overrun_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && inflight_q && !pop));

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rd_en     = issue;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head_data;
    assign bus.out_last  = head_last && !fifo_empty;

endmodule

// File: tb/tb_vram_stream_reader.sv
// Randomised bench for vram_stream_reader against a modulo-address stream model.
module tb_vram_stream_reader;
    import vram_pkg::*;

    localparam int DW   = 64;
    localparam int AW   = 11;
    localparam int MAXA = 2047;
    localparam int MEMN = MAXA + 1;
    localparam int OW   = 5 + AW + DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    vram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_ADDR   (MAXA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [MEMN];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_cyc  [$];
    int            iss_addr [$];
    int            stall_viol, max_outs, done_cyc, start_cyc;
    bit            timed_out, busy_at_done;
    logic [OW-1:0] ov;

    // Reference: word k of a burst is the RAM word at (base + k) modulo the memory size.
    function automatic logic [DW-1:0] exp_word(input int base, input int k);
        return mem[(base + k) % MEMN];
    endfunction

    task automatic do_start(input int addr, input int len);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.start_addr = AW'(addr);
        bus.len_m1     = AW'(len);
        @(posedge clk); #1;
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    // Drives out_ready (0: always, 1: fixed pattern, 2: random) and records handshakes until done.
    task automatic stream(input int mode, input int max_cycles, input int start2_at, input bit clr_on_last);
        int outs, pidx;
        bit prev_stall, prev_l, hs;
        logic [DW-1:0] prev_d;
        got_data.delete(); got_last.delete(); got_cyc.delete(); iss_addr.delete();
        stall_viol = 0; max_outs = 0; outs = 0; pidx = 0;
        prev_stall = 1'b0; prev_l = 1'b0; prev_d = '0;
        done_cyc = -1; busy_at_done = 1'b1; timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = pat[pidx % 8];
                default: bus.out_ready = ($urandom_range(0, 1) == 1);
            endcase
            bus.start = (c == start2_at);
            if (c == start2_at) begin
                bus.start_addr = AW'('h100);
                bus.len_m1     = AW'(5);
            end
            bus.clr_done = clr_on_last && bus.out_valid && bus.out_last && bus.out_ready;
            @(negedge clk);
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                got_data.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                got_cyc.push_back(cyc);
            end
            if (bus.out_valid) pidx++;
            if (bus.rd_en) iss_addr.push_back(int'(bus.rd_addr));
            if (prev_stall && !(bus.out_valid && bus.out_data == prev_d && bus.out_last == prev_l))
                stall_viol++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            prev_l     = bus.out_last;
            outs = outs + int'(bus.rd_en) - int'(hs);
            if (outs > max_outs) max_outs = outs;
            if (bus.done) begin
                done_cyc     = cyc;
                busy_at_done = bus.busy;
                timed_out    = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start    = 1'b0;
        bus.clr_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ov = {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_last, bus.out_data};
        n_cmp++;
        if (ov !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", ov); end
        rst_n = 1'b1;
        @(negedge clk);
        ov = {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_last, bus.out_data};
        n_cmp++;
        if (ov !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h expected 0", ov); end
    endtask

    task automatic test_basic();
        int n = 4;
        do_start('h010, n - 1);
        stream(0, 40, -1, 1'b0);
        n_cmp++;
        if (timed_out || got_data.size() != n) begin
            n_fail++; $display("FAIL basic_count: got %0d words expected %0d", got_data.size(), n);
        end
        for (int k = 0; k < got_data.size() && k < n; k++) begin
            n_cmp++;
            if (got_data[k] !== exp_word('h010, k) || got_last[k] !== (k == n - 1) ||
                got_cyc[k] !== start_cyc + 2 + k) begin
                n_fail++;
                $display("FAIL basic_word[%0d]: got %h last %0b cyc %0d expected %h last %0b cyc %0d", k,
                         got_data[k], got_last[k], got_cyc[k], exp_word('h010, k), k == n - 1, start_cyc + 2 + k);
            end
        end
        n_cmp++;
        if (done_cyc !== start_cyc + n + 2 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got cyc %0d busy %0b expected cyc %0d busy 0",
                     done_cyc, busy_at_done, start_cyc + n + 2);
        end
    endtask

    task automatic test_wrap();
        int n = 4;
        do_start(2046, n - 1);
        stream(0, 40, -1, 1'b0);
        n_cmp++;
        if (timed_out || got_data.size() != n) begin
            n_fail++; $display("FAIL wrap_count: got %0d words expected %0d", got_data.size(), n);
        end
        for (int k = 0; k < got_data.size() && k < n; k++) begin
            n_cmp++;
            if (got_data[k] !== exp_word(2046, k) || got_last[k] !== (k == n - 1)) begin
                n_fail++;
                $display("FAIL wrap_word[%0d]: got %h expected %h", k, got_data[k], exp_word(2046, k));
            end
        end
        n_cmp++;
        if (iss_addr.size() != n) begin
            n_fail++; $display("FAIL wrap_issues: got %0d reads expected %0d", iss_addr.size(), n);
        end
        for (int k = 0; k < iss_addr.size() && k < n; k++) begin
            n_cmp++;
            if (iss_addr[k] != (2046 + k) % MEMN) begin
                n_fail++; $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", k, iss_addr[k], (2046 + k) % MEMN);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int t = 0; t < 3; t++) begin
            int a = $urandom_range(0, MAXA);
            int n = (t == 0) ? 8 : $urandom_range(5, 24);
            do_start(a, n - 1);
            stream((t == 0) ? 1 : 2, 400, -1, 1'b0);
            n_cmp++;
            if (timed_out || got_data.size() != n) begin
                n_fail++; $display("FAIL bp%0d_count: got %0d words expected %0d", t, got_data.size(), n);
            end
            for (int k = 0; k < got_data.size() && k < n; k++) begin
                n_cmp++;
                if (got_data[k] !== exp_word(a, k) || got_last[k] !== (k == n - 1)) begin
                    n_fail++;
                    $display("FAIL bp%0d_word[%0d]: got %h expected %h", t, k, got_data[k], exp_word(a, k));
                end
            end
            n_cmp++;
            if (stall_viol != 0) begin n_fail++; $display("FAIL bp%0d_stable: got %0d changes expected 0", t, stall_viol); end
            n_cmp++;
            if (max_outs > 2) begin n_fail++; $display("FAIL bp%0d_outstanding: got %0d expected <=2", t, max_outs); end
        end
    endtask

    task automatic test_single_done();
        int a = $urandom_range(0, MAXA);
        int b = $urandom_range(0, MAXA);
        do_start(a, 0);
        stream(0, 20, -1, 1'b0);
        n_cmp++;
        if (timed_out || got_data.size() != 1 || got_data[0] !== exp_word(a, 0) || got_last[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_word: got %0d words expected 1 word %h with last", got_data.size(), exp_word(a, 0));
        end
        do_start(b, 4);
        stream(0, 40, -1, 1'b1);
        n_cmp++;
        if (timed_out || bus.done !== 1'b1) begin
            n_fail++; $display("FAIL done_set_over_clr: got done %0b expected 1", bus.done);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %0b expected 1", bus.done); end
        @(posedge clk); #1; bus.clr_done = 1'b1;
        @(posedge clk); #1; bus.clr_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_clear: got %0b expected 0", bus.done); end
    endtask

    task automatic test_start_busy();
        int a = $urandom_range(0, MAXA);
        int n = 10;
        int stray = 0;
        do_start(a, n - 1);
        stream(0, 60, 3, 1'b0);
        n_cmp++;
        if (timed_out || got_data.size() != n) begin
            n_fail++; $display("FAIL busy_start_count: got %0d words expected %0d", got_data.size(), n);
        end
        for (int k = 0; k < got_data.size() && k < n; k++) begin
            n_cmp++;
            if (got_data[k] !== exp_word(a, k) || got_last[k] !== (k == n - 1)) begin
                n_fail++; $display("FAIL busy_start_word[%0d]: got %h expected %h", k, got_data[k], exp_word(a, k));
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy || bus.rd_en) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_fail++; $display("FAIL busy_start_idle: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_reset_mid();
        int a = $urandom_range(0, MAXA);
        int b = $urandom_range(0, MAXA);
        int hs_n = 0;
        do_start(a, 9);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && hs_n < 2; c++) begin
            @(negedge clk);
            if (bus.out_valid) hs_n++;
        end
        n_cmp++;
        if (hs_n != 2) begin n_fail++; $display("FAIL rst_mid_prefix: got %0d words expected 2", hs_n); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        ov = {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_last, bus.out_data};
        n_cmp++;
        if (ov !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", ov); end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(b, 5);
        stream(2, 100, -1, 1'b0);
        n_cmp++;
        if (timed_out || got_data.size() != 6) begin
            n_fail++; $display("FAIL rst_mid_restart_count: got %0d words expected 6", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < 6; k++) begin
            n_cmp++;
            if (got_data[k] !== exp_word(b, k) || got_last[k] !== (k == 5)) begin
                n_fail++; $display("FAIL rst_mid_word[%0d]: got %h expected %h", k, got_data[k], exp_word(b, k));
            end
        end
    endtask

    task automatic test_random_and_full();
        for (int t = 0; t < 5; t++) begin
            int full = (t == 4);
            int a    = full ? $urandom_range(1, MAXA) : $urandom_range(0, MAXA);
            int n    = full ? MEMN : $urandom_range(1, 32);
            int errs = 0;
            do_start(a, n - 1);
            stream(full ? 0 : 2, 2 * n + 100, -1, 1'b0);
            n_cmp++;
            if (timed_out || got_data.size() != n) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d words expected %0d", t, got_data.size(), n);
            end
            for (int k = 0; k < got_data.size() && k < n; k++) begin
                n_cmp++;
                if (got_data[k] !== exp_word(a, k) || got_last[k] !== (k == n - 1)) begin
                    n_fail++; errs++;
                    if (errs < 5) $display("FAIL rand%0d_word[%0d]: got %h expected %h", t, k, got_data[k], exp_word(a, k));
                end
            end
            n_cmp++;
            if (max_outs > 2) begin n_fail++; $display("FAIL rand%0d_outstanding: got %0d expected <=2", t, max_outs); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < MEMN; a++) mem[a] = {$urandom(), 32'(a)};
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.len_m1     = '0;
        bus.clr_done   = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_single_done();
        test_start_busy();
        test_reset_mid();
        test_random_and_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_stream_reader.md
Name: vram_stream_reader

Overview:
- Streams a contiguous range of a VRAM copy out over a valid/ready interface, for PPU render pipes.
- Counterpart of the VRAM sync writer: the writer fills the PPU-side copy, and this block drains it.
- Talks to a 1-cycle-latency synchronous RAM read port.
- Absorbs downstream backpressure with a 2-entry buffer, so it never drops or duplicates a word.

Parameters:
DATA_WIDTH, 64, width of RAM word and stream data
ADDR_WIDTH, 11, RAM address width
MAX_ADDR, 2047, highest legal address; read address wraps from MAX_ADDR to 0; must be < 2^ADDR_WIDTH

Ports:
clk  in  1  clock (already decided)
rst_n  in  1  reset, asynchronous, active-low (already decided)
start  in  1  one-cycle request to begin a burst; ignored while busy
start_addr  in  ADDR_WIDTH  first word address, sampled with start
len_m1  in  ADDR_WIDTH  burst length minus 1, sampled with start; must be <= MAX_ADDR
busy  out  1  high from the cycle after start is accepted until the last word handshakes
done  out  1  sticky completion flag
clr_done  in  1  clears done
rd_addr  out  ADDR_WIDTH  RAM read address
rd_en  out  1  RAM read enable
rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after rd_en/rd_addr are sampled
out_data  out  DATA_WIDTH  stream data
out_valid  out  1  stream valid
out_last  out  1  marks the final word of the burst; qualified by out_valid
out_ready  in  1  downstream accept

Behaviour:
- Reset values: every output is 0, state is IDLE, buffer is empty, in-flight count is 0.
- Reset mid-burst aborts the burst. No partial done is reported.

State machine:
- IDLE: on start, latch start_addr (or 0 if start_addr > MAX_ADDR) and latch len_m1. Set remaining-issue count to len_m1+1, clear done, go to READ.
- READ: issue reads as allowed by the issue rule below. Go to DRAIN in the cycle the final read is issued.
- DRAIN: no new reads. Go to IDLE when the handshake with out_last=1 occurs, and set done=1 on that edge.

Issue rule:
- occ = buffer entries + reads in flight (in flight is 0 or 1).
- A read is issued in a cycle iff state==READ and (occ − pop_this_cycle) < 2, where pop = out_valid & out_ready.
- An issue drives rd_en=1 with the current address, then advances the address: +1, or 0 when the current address == MAX_ADDR.

Data path:
- rd_data is captured into the buffer on the edge after the issue cycle.
- The buffer is a 2-entry FIFO and is never overrun.
- out_data/out_valid come from the buffer head. out_valid is registered, with no combinational path from out_ready.
- out_last: a down-counter of words remaining to deliver, loaded with len_m1+1; out_last=1 when the head word is the last.

Latency and throughput:
- start sampled at edge E0 → rd_en high in the cycle after E0 → first out_valid high after E2 (2 cycles).
- With out_ready held at 1: one word per cycle; a burst of N words completes N+1 cycles after the first rd_en.

Backpressure:
- out_ready=0 stalls issue within at most 2 outstanding words.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.

done:
- Set-priority over clr_done.
- A start accepted in the same cycle as clr_done also clears done.
- Stays at 1 until cleared.

Boundary cases:
- len_m1=0: a single word, out_last=1 on it.
- len_m1=MAX_ADDR: the full memory, wrapping through 0 once when start_addr≠0.
- start while busy: ignored; latched parameters unchanged.
- busy falls on the same edge done rises.

Decomposition:
- Package vram_pkg: sr_state_t enum {IDLE, READ, DRAIN}; a localparam for buffer depth 2; an address-increment-with-wrap helper function shared with the sync writer.
- Sub-module stream_skid_fifo: 2-entry, parameterised DATA_WIDTH+1 bits (data + last). Ports: push, pop, full, empty, count. Simultaneous push and pop are legal when not empty.

Test Plan:
- Basic burst: start_addr=0x010, len_m1=3, RAM[a]=a, out_ready=1 → out_data 0x010..0x013 on 4 consecutive cycles beginning 2 cycles after start; out_last on 0x013; done=1 and busy=0 the next cycle.
- Wrap: MAX_ADDR=2047, start_addr=2046, len_m1=3 → stream 2046, 2047, 0, 1; rd_addr never exceeds 2047.
- Backpressure: len_m1=7, out_ready pattern 1,0,0,1,0,1,1,1… → all 8 words in order with no duplicates; out_data stable while stalled; never more than 2 reads outstanding (assertion).
- Single word plus done handling: len_m1=0 → one word with out_last=1. Then clr_done and a completion set in the same cycle of a second burst → done=1. clr_done alone → done=0.
- Start while busy: a second start with start_addr=0x100 mid-burst → ignored; the original burst completes unaltered.
- Reset mid-burst: rst_n low after 2 words → all outputs 0 immediately; a fresh start afterwards streams correctly from its own start_addr.
